bist_engine: RTL and testbench
==============================

// Module: bist_engine
// PURPOSE
// Parametrised self-test engine, successor of the 7-bit LFSR/controller BIST top. On a rising edge
// of bist_start it drives N_PATTERNS pseudo-random vectors from a W-bit LFSR into the circuit under
// test (CUT) and compresses CUT responses in a MISR. It then compares the signature with GOLDEN_SIG
// and reports pass/fail. Sits between the chip-level BIST pins and one CUT, with a bist_mode mux select.
// PARAMETERS
// LFSR_W      16        pattern generator width (>=3)
// LFSR_POLY   16'hB400  Galois feedback taps for the generator, bit i = tap on stage i
// LFSR_SEED   16'h0001  generator seed; an all-zero seed is replaced by 1
// MISR_W      16        signature / CUT response width (>=3)
// MISR_POLY   16'hB400  MISR feedback taps
// N_PATTERNS  1024      vectors per run (1..2^20)
// CUT_LAT     2         CUT response latency in cycles (0..15)
// GOLDEN_SIG  16'h0000  expected final MISR signature
// PORTS
// clk         in   1        clock, rising edge
// reset       in   1        asynchronous, active-low reset
// bist_start  in   1        run request; rising edge starts a run
// cut_out     in   MISR_W   CUT response, sampled every cycle
// cut_in      out  LFSR_W   test vector to CUT (current LFSR state)
// bist_mode   out  1        1 = CUT inputs taken from cut_in
// running     out  1        run in progress
// bist_end    out  1        run complete; held until the next start edge
// pass_nfail  out  1        1 = signature matched; valid while bist_end=1
// signature   out  MISR_W   final MISR contents; valid while bist_end=1
// BEHAVIOUR
// - Reset (async assert, sync release): FSM=IDLE, cut_in=LFSR_SEED, MISR=0, all 1-bit outputs 0, signature=0.
// - Start detect: registered prev_start. Edge k samples bist_start=1 with prev_start=0 => IDLE/DONE->RUN at k.
//   Starts seen while RUN/FLUSH/CMP are ignored. A start held high from reset does not fire until it drops and rises again.
// - Start edge action: load LFSR=LFSR_SEED, clear MISR and counters, clear bist_end/pass_nfail.
//   running=1 and bist_mode=1 from cycle k+1.
// - RUN: cut_in advances one Galois step per cycle. Pattern counter counts 0..N_PATTERNS-1.
//   After the last vector -> FLUSH.
// - Capture window: a CUT_LAT-deep valid shift line tracks applied vectors. The MISR absorbs cut_out
//   (misr <= step(misr) ^ cut_out) on exactly N_PATTERNS cycles, the first being CUT_LAT cycles after the first vector.
// - FLUSH: lasts CUT_LAT cycles (0 => skipped), then -> CMP.
// - CMP (1 cycle): signature<=misr; pass_nfail<=(misr==GOLDEN_SIG); running, bist_mode -> 0; -> DONE.
// - DONE: bist_end=1, outputs stable. A start edge begins a new run.
// - Total latency, start edge to bist_end=1: N_PATTERNS+CUT_LAT+2 cycles.
// - Reset mid-run aborts immediately to reset values. No partial signature or pass is ever reported.
// - The LFSR never enters the all-zero state (zero seed forced to 1). Counter width = clog2(N_PATTERNS+1).
// STRUCTURE
// - Package bist_pkg: state enum {IDLE,RUN,FLUSH,CMP,DONE}, default polynomials, clog2 helper constant.
// - Sub-module lfsr_misr (WIDTH, POLY, MISR_EN): one Galois register with load/enable/parallel input.
//   Instantiated twice: generator (parallel input tied 0) and MISR.
// - Top: edge detector, FSM, pattern counter, latency shift line, compare register.
// TESTING
// 1 Reset asserted mid-RUN (cycle 5) -> all outputs 0 asynchronously, cut_in=seed, no bist_end after release.
// 2 N_PATTERNS=8, CUT_LAT=0, cut_out tied to cut_in[MISR_W-1:0], GOLDEN_SIG from C model
//   -> bist_end high at cycle 10, pass_nfail=1, signature==GOLDEN_SIG.
// 3 Same as 2 with one cut_out bit flipped on pattern 4 -> pass_nfail=0, signature!=GOLDEN_SIG.
// 4 CUT_LAT=3, CUT modelled as 3-stage delay -> pass_nfail=1, bist_end at cycle N_PATTERNS+5.
// 5 Extra start pulses during RUN are ignored (cut_in sequence unchanged); start in DONE
//   -> bist_end drops next cycle and the run repeats with an identical signature.
// 6 LFSR_SEED=0, LFSR_W=4, POLY=4'hC -> cut_in starts at 1, cycles all 15 nonzero states, never 0.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared FSM encodings, default polynomial and counter sizing for the BIST engine.
// Pure declarations; no timing or flow-control behaviour.
package bist_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_CMP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [15:0] DEF_POLY = 16'hB400;

  // Pattern counter must hold values up to N_PATTERNS.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lfsr_misr.sv
// Right-shifting Galois register: pattern generator (MISR_EN=0) or signature compactor (MISR_EN=1).
// One step per enabled cycle; load has priority over enable; no backpressure.
module lfsr_misr #(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] POLY    = 16'hB400,
  parameter bit               MISR_EN = 1'b0,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_par,
  output logic [WIDTH-1:0] o_state
);

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] w_next;

  always_comb begin
    w_next = (r_state >> 1) ^ (r_state[0] ? POLY : '0);
    if (MISR_EN) begin
      w_next = w_next ^ i_par;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= RST_VAL;
    end else if (i_load) begin
      r_state <= i_load_val;
    end else if (i_en) begin
      r_state <= w_next;
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/bist_engine.sv
// Self-test controller: LFSR vectors into one CUT, MISR compaction, golden compare.
// Start edge to bist_end in N_PATTERNS+CUT_LAT+1 clock edges; starts outside IDLE/DONE are ignored.
module bist_engine
  import bist_pkg::*;
#(
  parameter int                LFSR_W     = 16,
  parameter logic [LFSR_W-1:0] LFSR_POLY  = DEF_POLY,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = 16'h0001,
  parameter int                MISR_W     = 16,
  parameter logic [MISR_W-1:0] MISR_POLY  = DEF_POLY,
  parameter int                N_PATTERNS = 1024,
  parameter int                CUT_LAT    = 2,
  parameter logic [MISR_W-1:0] GOLDEN_SIG = 16'h0000
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_bist_start,
  input  logic [MISR_W-1:0] i_cut_out,
  output logic [LFSR_W-1:0] o_cut_in,
  output logic              o_bist_mode,
  output logic              o_running,
  output logic              o_bist_end,
  output logic              o_pass_nfail,
  output logic [MISR_W-1:0] o_signature
);

  localparam int                CNT_W    = cnt_width(N_PATTERNS);
  localparam int                LINE_W   = (CUT_LAT > 0) ? CUT_LAT : 1;
  localparam logic [LFSR_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;

  logic [2:0]        r_state;
  logic              r_prev_start;
  logic [CNT_W-1:0]  r_cnt;
  logic [3:0]        r_flush_cnt;
  logic [LINE_W-1:0] r_vld_line;
  logic              r_running;
  logic              r_bist_mode;
  logic              r_bist_end;
  logic              r_pass;
  logic [MISR_W-1:0] r_sig;

  logic              w_start;
  logic              w_cap_en;
  logic [MISR_W-1:0] w_misr;

  assign w_start = i_bist_start & ~r_prev_start & ((r_state == S_IDLE) | (r_state == S_DONE));
  // Responses lag their vectors by CUT_LAT cycles; the line marks which cycles carry one.
  assign w_cap_en = (CUT_LAT == 0) ? (r_state == S_RUN) : r_vld_line[LINE_W-1];

  lfsr_misr #(.WIDTH(LFSR_W), .POLY(LFSR_POLY), .MISR_EN(1'b0), .RST_VAL(SEED_EFF)) u_gen (
    .i_clk(i_clk), .i_rst_n(i_reset_n), .i_load(w_start), .i_load_val(SEED_EFF),
    .i_en(r_state == S_RUN), .i_par('0), .o_state(o_cut_in)
  );

  lfsr_misr #(.WIDTH(MISR_W), .POLY(MISR_POLY), .MISR_EN(1'b1), .RST_VAL('0)) u_misr (
    .i_clk(i_clk), .i_rst_n(i_reset_n), .i_load(w_start), .i_load_val('0),
    .i_en(w_cap_en), .i_par(i_cut_out), .o_state(w_misr)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= S_IDLE;
      r_prev_start <= 1'b1;  // a start held through reset must drop before it counts
      r_cnt        <= '0;
      r_flush_cnt  <= '0;
      r_vld_line   <= '0;
      r_running    <= 1'b0;
      r_bist_mode  <= 1'b0;
      r_bist_end   <= 1'b0;
      r_pass       <= 1'b0;
      r_sig        <= '0;
    end else begin
      r_prev_start <= i_bist_start;
      r_vld_line   <= w_start ? '0 : ((r_vld_line << 1) | LINE_W'(r_state == S_RUN));
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start) begin
            r_state     <= S_RUN;
            r_cnt       <= '0;
            r_flush_cnt <= '0;
            r_running   <= 1'b1;
            r_bist_mode <= 1'b1;
            r_bist_end  <= 1'b0;
            r_pass      <= 1'b0;
          end
        end
        S_RUN: begin
          if (r_cnt == CNT_W'(N_PATTERNS - 1)) begin
            r_state     <= (CUT_LAT == 0) ? S_CMP : S_FLUSH;
            r_flush_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FLUSH: begin
          if (r_flush_cnt == 4'(CUT_LAT - 1)) begin
            r_state <= S_CMP;
          end else begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
          end
        end
        S_CMP: begin
          r_sig       <= w_misr;
          r_pass      <= (w_misr == GOLDEN_SIG);
          r_running   <= 1'b0;
          r_bist_mode <= 1'b0;
          r_bist_end  <= 1'b1;
          r_state     <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_bist_mode  = r_bist_mode;
  assign o_running    = r_running;
  assign o_bist_end   = r_bist_end;
  assign o_pass_nfail = r_pass;
  assign o_signature  = r_sig;

endmodule

// File: tb/tb_bist_engine.sv
// Directed + randomized bench for bist_engine across three parameter sets.
// Expected vectors and signatures come from a plain arithmetic model of the LFSR/MISR rules.
module tb_bist_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic logic [31:0] gstep(input logic [31:0] x, input logic [31:0] poly);
    return (x >> 1) ^ (x[0] ? poly : 32'd0);
  endfunction

  // Signature of a fault-free CUT that returns each vector unchanged.
  function automatic logic [31:0] ref_sig(input int n, input logic [31:0] poly);
    logic [31:0] g;
    logic [31:0] m;
    g = 32'd1;
    m = 32'd0;
    for (int i = 0; i < n; i++) begin
      m = gstep(m, poly) ^ g;
      g = gstep(g, poly);
    end
    return m;
  endfunction

  localparam logic [31:0] REF_A = ref_sig(8, 32'hB400);
  localparam logic [31:0] REF_B = ref_sig(20, 32'hB400);
  localparam logic [15:0] GOLD_A = REF_A[15:0];
  localparam logic [15:0] GOLD_B = REF_B[15:0];

  // Instance A: N=8, no latency, CUT echoes its vector (optional single-bit fault)
  logic        rst_a, start_a, flip_a, mode_a, run_a, end_a, pass_a;
  logic [15:0] cut_in_a, cut_out_a, sig_a;
  assign cut_out_a = cut_in_a ^ (flip_a ? 16'h0010 : 16'h0000);

  bist_engine #(.LFSR_W(16), .LFSR_POLY(16'hB400), .LFSR_SEED(16'h0001), .MISR_W(16),
                .MISR_POLY(16'hB400), .N_PATTERNS(8), .CUT_LAT(0), .GOLDEN_SIG(GOLD_A)) u_a (
    .i_clk(clk), .i_reset_n(rst_a), .i_bist_start(start_a), .i_cut_out(cut_out_a),
    .o_cut_in(cut_in_a), .o_bist_mode(mode_a), .o_running(run_a), .o_bist_end(end_a),
    .o_pass_nfail(pass_a), .o_signature(sig_a));

  // Instance B: N=20, CUT_LAT=3, CUT is a 3-stage delay or random responses
  logic        rst_b, start_b, rand_en, mode_b, run_b, end_b, pass_b;
  logic [15:0] cut_in_b, cut_out_b, sig_b, rand_b, d1, d2, d3;
  always @(posedge clk) begin
    d1 <= cut_in_b;
    d2 <= d1;
    d3 <= d2;
  end
  assign cut_out_b = rand_en ? rand_b : d3;

  bist_engine #(.LFSR_W(16), .LFSR_POLY(16'hB400), .LFSR_SEED(16'h0001), .MISR_W(16),
                .MISR_POLY(16'hB400), .N_PATTERNS(20), .CUT_LAT(3), .GOLDEN_SIG(GOLD_B)) u_b (
    .i_clk(clk), .i_reset_n(rst_b), .i_bist_start(start_b), .i_cut_out(cut_out_b),
    .o_cut_in(cut_in_b), .o_bist_mode(mode_b), .o_running(run_b), .o_bist_end(end_b),
    .o_pass_nfail(pass_b), .o_signature(sig_b));

  // Instance C: 4-bit generator, zero seed
  logic       rst_c, start_c, mode_c, run_c, end_c, pass_c;
  logic [3:0] cut_in_c, sig_c;

  bist_engine #(.LFSR_W(4), .LFSR_POLY(4'hC), .LFSR_SEED(4'h0), .MISR_W(4),
                .MISR_POLY(4'hC), .N_PATTERNS(20), .CUT_LAT(0), .GOLDEN_SIG(4'h0)) u_c (
    .i_clk(clk), .i_reset_n(rst_c), .i_bist_start(start_c), .i_cut_out(cut_in_c),
    .o_cut_in(cut_in_c), .o_bist_mode(mode_c), .o_running(run_c), .o_bist_end(end_c),
    .o_pass_nfail(pass_c), .o_signature(sig_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic sel_end(input int which);
    return (which == 0) ? end_a : (which == 1) ? end_b : end_c;
  endfunction

  task automatic wait_end(input int which, output int cyc);
    cyc = 0;
    while (sel_end(which) == 1'b0 && cyc < 500) begin
      tick();
      cyc++;
    end
    check("end_timeout", 32'(sel_end(which)), 32'd1);
  endtask

  initial begin
    int          cyc;
    int          seen_cnt;
    logic [31:0] g;
    logic [31:0] m;
    logic [15:0] seen;

    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    start_a = 1'b1; start_b = 1'b0; start_c = 1'b0;
    flip_a = 1'b0; rand_en = 1'b0; rand_b = 16'h0;
    tick();
    tick();

    check("rst_cut_in", 32'(cut_in_a), 32'h1);
    check("rst_running", 32'(run_a), 32'd0);
    check("rst_mode", 32'(mode_a), 32'd0);
    check("rst_end", 32'(end_a), 32'd0);
    check("rst_pass", 32'(pass_a), 32'd0);
    check("rst_sig", 32'(sig_a), 32'd0);
    check("rst_zero_seed", 32'(cut_in_c), 32'h1);

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    repeat (3) tick();
    check("held_start_ignored", 32'(run_a), 32'd0);
    start_a = 1'b0;
    tick();

    // Reset in the middle of a run
    start_a = 1'b1; tick(); start_a = 1'b0;
    check("start_running", 32'(run_a), 32'd1);
    check("start_mode", 32'(mode_a), 32'd1);
    check("start_seed", 32'(cut_in_a), 32'h1);
    repeat (4) tick();
    rst_a = 1'b0;
    #1;
    check("abort_running", 32'(run_a), 32'd0);
    check("abort_mode", 32'(mode_a), 32'd0);
    check("abort_cut_in", 32'(cut_in_a), 32'h1);
    check("abort_end", 32'(end_a), 32'd0);
    check("abort_sig", 32'(sig_a), 32'd0);
    tick();
    rst_a = 1'b1;
    seen_cnt = 0;
    repeat (15) begin
      tick();
      if (end_a || run_a) seen_cnt++;
    end
    check("abort_quiet", 32'(seen_cnt), 32'd0);

    // Fault-free run, latency N+L+1 edges after the start edge
    start_a = 1'b1; tick(); start_a = 1'b0;
    wait_end(0, cyc);
    check("a_latency", 32'(cyc), 32'd9);
    check("a_pass", 32'(pass_a), 32'd1);
    check("a_sig", 32'(sig_a), 32'(GOLD_A));
    check("a_running_off", 32'(run_a), 32'd0);
    check("a_mode_off", 32'(mode_a), 32'd0);

    // Single-bit fault on pattern 4
    start_a = 1'b1; tick(); start_a = 1'b0;
    repeat (4) tick();
    flip_a = 1'b1; tick(); flip_a = 1'b0;
    wait_end(0, cyc);
    check("flip_latency", 32'(cyc + 5), 32'd9);
    g = 32'd1; m = 32'd0;
    for (int i = 0; i < 8; i++) begin
      m = gstep(m, 32'hB400) ^ g ^ ((i == 4) ? 32'h10 : 32'h0);
      g = gstep(g, 32'hB400);
    end
    check("flip_pass", 32'(pass_a), 32'd0);
    check("flip_sig", 32'(sig_a), m);
    check("flip_sig_ne_gold", 32'(sig_a != GOLD_A), 32'd1);

    // Start pulses during RUN are ignored; restart from DONE repeats the run
    start_a = 1'b1; tick(); start_a = 1'b0;
    g = 32'd1;
    for (int j = 0; j < 8; j++) begin
      check("run_cut_in_seq", 32'(cut_in_a), g);
      g = gstep(g, 32'hB400);
      start_a = (j == 2 || j == 5);
      tick();
    end
    start_a = 1'b0;
    wait_end(0, cyc);
    check("pulses_sig", 32'(sig_a), 32'(GOLD_A));
    check("pulses_pass", 32'(pass_a), 32'd1);
    start_a = 1'b1; tick(); start_a = 1'b0;
    check("restart_end_drop", 32'(end_a), 32'd0);
    check("restart_running", 32'(run_a), 32'd1);
    wait_end(0, cyc);
    check("restart_latency", 32'(cyc), 32'd9);
    check("restart_sig", 32'(sig_a), 32'(GOLD_A));

    // Delayed CUT, CUT_LAT=3
    start_b = 1'b1; tick(); start_b = 1'b0;
    wait_end(1, cyc);
    check("b_latency", 32'(cyc), 32'd24);
    check("b_pass", 32'(pass_b), 32'd1);
    check("b_sig", 32'(sig_b), 32'(GOLD_B));

    // Random responses: the MISR absorbs edges k+4 .. k+23
    rand_en = 1'b1;
    for (int r = 0; r < 3; r++) begin
      m = 32'd0;
      start_b = 1'b1; tick(); start_b = 1'b0;
      for (int j = 1; j <= 24; j++) begin
        rand_b = 16'($urandom);
        if (j >= 4 && j <= 23) m = gstep(m, 32'hB400) ^ 32'(rand_b);
        tick();
        if (j == 23) check("rand_end_early", 32'(end_b), 32'd0);
      end
      check("rand_end", 32'(end_b), 32'd1);
      check("rand_sig", 32'(sig_b), m);
      check("rand_pass", 32'(pass_b), 32'(m[15:0] == GOLD_B));
    end
    rand_en = 1'b0;

    // Zero seed, 4-bit maximal generator
    start_c = 1'b1; tick(); start_c = 1'b0;
    g = 32'd1;
    seen = 16'h0;
    for (int j = 0; j < 15; j++) begin
      check("c_seq", 32'(cut_in_c), g);
      seen[cut_in_c] = 1'b1;
      g = gstep(g, 32'hC);
      tick();
    end
    check("c_wrap", 32'(cut_in_c), 32'h1);
    check("c_all_nonzero", 32'(seen), 32'hFFFE);
    wait_end(2, cyc);
    check("c_sig", 32'(sig_c), ref_sig(20, 32'hC));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
